pickup_train_station: RTL

PICKUP_TRAIN_STATION -- requirements
Module: pickup_train_station

---
 rtl/pickup_train_station.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pickup_train_station.sv
// Pickup station controller: a two-stage pipeline derives the uncommitted stock share
// and the train limit, and a small FSM runs load/depart handshaking for the stopped train.
module pickup_train_station #(
  parameter int QUEUE_LENGTH        = 3,
  parameter int MAX_STOREABLE       = 128000,
  parameter int UNITS_IN_TRAIN_LOAD = 8000,
  parameter int LOAD_TIMEOUT        = 600,
  parameter int INT                 = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [INT:0] precision,
  input  logic [INT:0] number_of_stations,
  input  logic [INT:0] total_percentage_available,
  input  logic [INT:0] units_at_this_station,
  input  logic [INT:0] train_count,
  input  logic [INT:0] stopped_train_id,
  input  logic [INT:0] stopped_train_cargo,
  output logic [INT:0] percentage_available,
  output logic [INT:0] trains_limit,
  output logic         load_enable,
  output logic         depart
);

  localparam int DW = INT + 1;
  localparam int WW = 2 * DW;
  localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT + 1) : 1;

  localparam logic [WW-1:0] W_W  = WW'(UNITS_IN_TRAIN_LOAD);
  localparam logic [WW-1:0] M_W  = WW'(MAX_STOREABLE);
  localparam logic [WW-1:0] Q_W  = WW'(QUEUE_LENGTH);
  localparam logic [WW-1:0] MAXC = (WW'(1) << INT) - WW'(1);
  localparam logic [DW-1:0] W_N  = DW'(UNITS_IN_TRAIN_LOAD);
  localparam logic [TW-1:0] TO_N = TW'(LOAD_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_LOADING, ST_DEPART} state_e;

  // Stage 1: committed stock, fair-share average, and aligned copies of C and P
  logic [DW-1:0] committed_d, committed_q, count_q, prec_q;
  logic [WW-1:0] avg_d, avg_q;
  logic [WW-1:0] stopped_w, r_w, p_w, g_w;
  logic signed [WW-1:0] trains_s, diff_s;

  always_comb begin
    stopped_w = {{(WW-1){1'b0}}, (stopped_train_id != '0)};
    trains_s  = $signed({{DW{1'b0}}, train_count} - stopped_w);
    diff_s    = $signed({{DW{1'b0}}, units_at_this_station}) - trains_s * $signed(W_W);
    if (diff_s[WW-1])
      committed_d = '0;
    else if (diff_s > $signed(MAXC))
      committed_d = MAXC[DW-1:0];
    else
      committed_d = diff_s[DW-1:0];

    r_w = {{DW{1'b0}}, total_percentage_available};
    p_w = {{DW{1'b0}}, precision};
    g_w = {{DW{1'b0}}, number_of_stations};
    // A zero precision would divide by zero; treat it like an empty network
    if (number_of_stations == '0 || precision == '0)
      avg_d = '0;
    else
      avg_d = ((r_w * p_w) / g_w) / p_w;
  end

  // Stage 2: share of buffer and train limit
  logic [WW-1:0] s_wide;
  logic [DW-1:0] s_d, s_q, l_d, l_q;
  logic          room;

  always_comb begin
    s_wide = ({{DW{1'b0}}, committed_q} * {{DW{1'b0}}, prec_q}) / M_W;
    s_d    = s_wide[DW-1:0];
    room   = ({{DW{1'b0}}, committed_q} >= W_W) && (s_wide >= avg_q)
             && ({{DW{1'b0}}, count_q} < Q_W);
    l_d    = room ? count_q + DW'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed_q <= '0;
      count_q     <= '0;
      prec_q      <= '0;
      avg_q       <= '0;
      s_q         <= '0;
      l_q         <= '0;
    end else begin
      committed_q <= committed_d;
      count_q     <= train_count;
      prec_q      <= precision;
      avg_q       <= avg_d;
      s_q         <= s_d;
      l_q         <= l_d;
    end
  end

  assign percentage_available = s_q;
  assign trains_limit         = l_q;

  // Loading FSM
  state_e        state_d, state_q;
  logic [DW-1:0] id_d, id_q, last_d, last_q;
  logic [TW-1:0] timer_d, timer_q;
  logic          load_en_q, depart_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (stopped_train_id != '0) begin
          state_d = ST_LOADING;
          id_d    = stopped_train_id;
          last_d  = stopped_train_cargo;
          timer_d = '0;
        end
      end
      ST_LOADING: begin
        if (stopped_train_id == '0) begin
          state_d = ST_IDLE;
        end else if (stopped_train_id != id_q) begin
          id_d    = stopped_train_id;
          last_d  = stopped_train_cargo;
          timer_d = '0;
        end else begin
          if (stopped_train_cargo > last_q) begin
            last_d  = stopped_train_cargo;
            timer_d = '0;
          end else if (timer_q != TO_N) begin
            timer_d = timer_q + TW'(1);
          end
          if (stopped_train_cargo >= W_N || timer_d == TO_N)
            state_d = ST_DEPART;
        end
      end
      ST_DEPART: begin
        if (stopped_train_id == '0 || stopped_train_id != id_q)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      last_q    <= '0;
      timer_q   <= '0;
      load_en_q <= 1'b0;
      depart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      load_en_q <= (state_d == ST_LOADING);
      depart_q  <= (state_d == ST_DEPART);
    end
  end

  assign load_enable = load_en_q;
  assign depart      = depart_q;

endmodule
